// File: rtl/ws2812_pkg.sv
// ws2812_pkg: state encoding and default timing constants shared by the WS2812 receiver and transmitter
package ws2812_pkg;

    typedef enum logic [1:0] {ST_SYNC, ST_LOW, ST_HIGH, ST_PASS} ws2812_state_t;

    localparam int BIT_THRESH_DEF = 14;
    localparam int MIN_HIGH_DEF   = 3;
    localparam int MAX_HIGH_DEF   = 30;
    localparam int RESET_LOW_DEF  = 1200;
    localparam int T1H_DEF        = 20;
    localparam int T0H_DEF        = 8;
    localparam int T_BIT_DEF      = 30;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > d ? m : d;
    endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: serial line in, decoded pixel and event pulses out
interface ws2812_rx_if;

    logic        i_Din;
    logic [23:0] o_Colour;
    logic        o_Valid;
    logic        o_Frame_End;
    logic        o_Error;
    logic        o_Dout;

    modport master (output i_Din, input o_Colour, o_Valid, o_Frame_End, o_Error, o_Dout);
    modport slave  (input i_Din, output o_Colour, o_Valid, o_Frame_End, o_Error, o_Dout);

endinterface

// File: rtl/ws2812_pulse_meter.sv
// ws2812_pulse_meter: synchronises the serial line and measures the length of each level run
module ws2812_pulse_meter #(
    parameter int CNT_W = 11,
    parameter int SAT   = 1200
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Din,
    output logic             din_s,
    output logic             din_edge,
    output logic [CNT_W-1:0] run,
    output logic [CNT_W-1:0] run_q,
    output logic             gap
);

    localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);

    logic sync1;
    logic din_d;

    // two-flop synchroniser, previous synchronised level and previous run length
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync1 <= 1'b0;
            din_s <= 1'b0;
            din_d <= 1'b0;
            run_q <= '0;
        end else begin
            sync1 <= i_Din;
            din_s <= sync1;
            din_d <= din_s;
            run_q <= run;
        end
    end

    // run length including this cycle, saturating so it never wraps; gap fires once per long low
    always_comb begin
        din_edge = din_s ^ din_d;
        run      = din_edge ? CNT_W'(1) : (run_q == SAT_V ? run_q : run_q + CNT_W'(1));
        gap      = !din_s && run == SAT_V && run_q != SAT_V;
    end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes WS2812 pulse-width serial data into 24-bit pixels and forwards the rest of the chain
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int BIT_THRESH = BIT_THRESH_DEF,
    parameter int MIN_HIGH   = MIN_HIGH_DEF,
    parameter int MAX_HIGH   = MAX_HIGH_DEF,
    parameter int RESET_LOW  = RESET_LOW_DEF
) (
    input logic        i_Clock,
    input logic        i_Reset_n,
    ws2812_rx_if.slave bus
);

    localparam int CNT_W = $clog2(max4(BIT_THRESH, MIN_HIGH, MAX_HIGH, RESET_LOW) + 1);
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_HIGH);

    ws2812_state_t    state, state_n;
    logic             din_s, din_edge, gap, rise, fall, over, bit_v;
    logic [CNT_W-1:0] run, run_q;
    logic [4:0]       bit_cnt, bit_cnt_n;
    logic [22:0]      shift, shift_n;
    logic [23:0]      colour, colour_n;
    logic             act, act_n;
    logic             valid_q, valid_n, fe_q, fe_n, err_q, err_n;

    ws2812_pulse_meter #(.CNT_W(CNT_W), .SAT(RESET_LOW)) u_meter (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Din     (bus.i_Din),
        .din_s     (din_s),
        .din_edge  (din_edge),
        .run       (run),
        .run_q     (run_q),
        .gap       (gap)
    );

    assign rise  = din_edge && din_s;
    assign fall  = din_edge && !din_s;
    assign over  = din_s && run > MAX_V;
    assign bit_v = run_q >= THRESH_V;

    // state, pixel assembly and registered event pulses
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state   <= ST_SYNC;
            bit_cnt <= '0;
            shift   <= '0;
            colour  <= '0;
            act     <= 1'b0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            colour  <= colour_n;
            act     <= act_n;
            valid_q <= valid_n;
            fe_q    <= fe_n;
            err_q   <= err_n;
        end
    end

    // decoder: on a falling edge the just-ended high run (run_q) is the pulse width
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        colour_n  = colour;
        act_n     = act;
        valid_n   = 1'b0;
        fe_n      = 1'b0;
        err_n     = 1'b0;
        case (state)
            ST_SYNC: begin
                if (gap) begin
                    state_n   = ST_LOW;
                    bit_cnt_n = '0;
                    act_n     = 1'b0;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_n = ST_HIGH;
                    act_n   = 1'b1;
                end else if (gap) begin
                    err_n     = bit_cnt != '0;
                    fe_n      = bit_cnt == '0 && act;
                    bit_cnt_n = '0;
                    act_n     = 1'b0;
                end
            end
            ST_HIGH: begin
                if (over) begin
                    err_n     = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = ST_SYNC;
                end else if (fall) begin
                    state_n = ST_LOW;
                    if (run_q < MIN_V) begin
                        err_n = 1'b1;
                    end else if (bit_cnt == 5'd23) begin
                        colour_n  = {shift, bit_v};
                        valid_n   = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = ST_PASS;
                    end else begin
                        shift_n   = {shift[21:0], bit_v};
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end
            end
            ST_PASS: begin
                if (over) begin
                    err_n   = 1'b1;
                    state_n = ST_SYNC;
                end else if (gap) begin
                    fe_n      = 1'b1;
                    bit_cnt_n = '0;
                    act_n     = 1'b0;
                    state_n   = ST_LOW;
                end
            end
            default: state_n = ST_SYNC;
        endcase
    end

    assign bus.o_Colour    = colour;
    assign bus.o_Valid     = valid_q;
    assign bus.o_Frame_End = fe_q;
    assign bus.o_Error     = err_q;
    assign bus.o_Dout      = state == ST_PASS && din_s;

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter: BIT_THRESH, 14, high-pulse cycles at or above which a bit decodes as 1.
REQ-002 Parameter: MIN_HIGH, 3, high-pulse cycles below which a pulse is a glitch.
REQ-003 Parameter: MAX_HIGH, 30, high-pulse cycles above which the line is faulted.
REQ-004 Parameter: RESET_LOW, 1200, low cycles constituting a frame-reset gap.
REQ-005 i_Clock  input  1  sole clock; all logic on rising edge.
REQ-006 i_Reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_Din  input  1  asynchronous WS2812 serial line.
REQ-008 o_Colour  output  24  last captured pixel, GRB order as received, MSB first in time at bit 23.
REQ-009 o_Valid  output  1  one-cycle pulse when o_Colour updates.
REQ-010 o_Frame_End  output  1  one-cycle pulse when a reset gap completes after any activity.
REQ-011 o_Error  output  1  one-cycle pulse on glitch, over-long high or partial pixel.
REQ-012 o_Dout  output  1  chain forwarding output (synchronised line during PASS, else 0).

Function
REQ-013 i_Din SHALL pass through a 2-flop synchroniser; all timing is measured on its output (din_s).
REQ-014 States SHALL be SYNC, LOW, HIGH, PASS.
REQ-015 SYNC: count consecutive low cycles; any high clears count; count reaching RESET_LOW -> LOW, no o_Frame_End.
REQ-016 LOW: count low cycles (saturating at RESET_LOW); rising din_s -> HIGH with high count = 1.
REQ-017 LOW: low count reaching RESET_LOW with bit count 0 and activity since last gap -> o_Frame_End pulse; bit count non-zero -> o_Error pulse, bit count cleared, no o_Valid.
REQ-018 HIGH: count high cycles; falling din_s -> decode and return to LOW with low count = 1.
REQ-019 Decode: high count < MIN_HIGH -> o_Error, bit discarded; >= BIT_THRESH -> 1; else 0; bit shifted into LSB of 24-bit shift register.
REQ-020 HIGH: high count exceeding MAX_HIGH -> o_Error, bit count cleared, -> SYNC.
REQ-021 24th valid bit: o_Colour <= shift register, o_Valid pulse in cycle after falling din_s is seen, -> PASS.
REQ-022 PASS: o_Dout = din_s; count low cycles; RESET_LOW reached -> o_Frame_End, o_Dout = 0, bit count cleared, -> LOW; high longer than MAX_HIGH -> o_Error, -> SYNC.
REQ-023 Outside PASS o_Dout SHALL be 0.
REQ-024 o_Colour SHALL hold its value until the next complete pixel; partial pixels never alter it.
REQ-025 Counters SHALL be sized by $clog2 of the largest parameter + 1 and never wrap.
REQ-026 At most one of o_Valid / o_Error SHALL assert per cycle; a 24th bit that is a glitch gives o_Error only.

Reset
REQ-027 On i_Reset_n low: state SYNC, counters 0, synchroniser flops 0, o_Colour 24'h0, o_Valid/o_Frame_End/o_Error/o_Dout 0.
REQ-028 Reset mid-pixel SHALL discard the partial pixel; after release the block SHALL require a full RESET_LOW gap before decoding.

Structure
REQ-029 State encoding and default timing constants SHALL live in shared package ws2812_pkg, also used by the WS2812 transmitter.
REQ-030 Pulse-width measurement MAY be a sub-module ws2812_pulse_meter (synchroniser + high/low counters); decoder FSM stays in ws2812_rx.

Verification
REQ-031 Reset release, 1200 low, pixel 24'hA5_3C_F0 (1=20 cycles high, 0=8 high, period 30) -> o_Valid once, o_Colour = 24'hA53CF0, then o_Frame_End after 1200 low.
REQ-032 Two pixels 24'h123456 then 24'hFFFFFF -> one o_Valid for 24'h123456; o_Dout reproduces second pixel's waveform delayed 2 cycles; o_Colour unchanged.
REQ-033 12 bits then 1200 low -> o_Error once, no o_Valid, o_Colour unchanged, next pixel 24'h000001 decodes correctly.
REQ-034 2-cycle high glitch mid-pixel -> o_Error, bit dropped; 40-cycle high -> o_Error, SYNC, next pixel ignored until 1200-cycle gap.
REQ-035 i_Reset_n asserted after 10 bits -> outputs zero immediately; pixel sent without preceding gap is ignored; pixel after gap decodes.
REQ-036 High of exactly 13 and 14 cycles -> decode 0 and 1 respectively.
